// File: rtl/alarm_annunciator_if.sv
// rtl/alarm_annunciator_if.sv - alarm/keypad/disarm signal bundle between controller and annunciator
interface alarm_annunciator_if;
  logic       alarm_in;
  logic       key_valid;
  logic [3:0] key_data;
  logic       disarm_ack;
  logic       siren;
  logic       strobe;
  logic       disarm_req;
  logic       lockout;
  logic [2:0] status;

  modport master (
    output alarm_in, key_valid, key_data, disarm_ack,
    input  siren, strobe, disarm_req, lockout, status
  );

  modport slave (
    input  alarm_in, key_valid, key_data, disarm_ack,
    output siren, strobe, disarm_req, lockout, status
  );
endinterface

// File: rtl/alarm_annunciator.sv
// rtl/alarm_annunciator.sv - siren/strobe annunciator with keypad disarm, req/ack handshake and lockout
module alarm_annunciator #(
  parameter logic [15:0] CODE            = 16'h1234,
  parameter int          PRESCALE        = 1000,
  parameter int          SIREN_ON_TICKS  = 4,
  parameter int          SIREN_OFF_TICKS = 4,
  parameter int          DIGIT_TIMEOUT   = 16,
  parameter int          MAX_TRIES       = 3
) (
  input logic                clk,
  input logic                rst_n,
  alarm_annunciator_if.slave bus
);

  localparam int PW    = $clog2(PRESCALE);
  localparam int PAT_N = SIREN_ON_TICKS + SIREN_OFF_TICKS;
  localparam int PATW  = $clog2(PAT_N);
  localparam int TW    = $clog2(DIGIT_TIMEOUT + 1);
  localparam int WCW   = $clog2(2 * PRESCALE);

  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [PATW-1:0] PAT_MAX   = PATW'(PAT_N - 1);
  localparam logic [PATW-1:0] PAT_ON    = PATW'(SIREN_ON_TICKS);
  localparam logic [TW-1:0]   TMO_MAX   = TW'(DIGIT_TIMEOUT);
  localparam logic [WCW-1:0]  WC_MAX    = WCW'(2 * PRESCALE - 1);
  localparam logic [2:0]      TRY_MAX   = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SOUNDING   = 3'd1,
    REQ        = 3'd2,
    WAIT_CLEAR = 3'd3,
    LOCKOUT    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [PATW-1:0] pat_q, pat_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [WCW-1:0]  wc_q, wc_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     entry_q, entry_d;
  logic            cmp_q, cmp_d;
  logic [2:0]      tries_q, tries_d;
  logic            siren_q, siren_d;
  logic            strobe_q, strobe_d;
  logic            req_q, req_d;
  logic            lock_q, lock_d;
  logic            running, tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      pat_q    <= '0;
      tmo_q    <= '0;
      wc_q     <= '0;
      idx_q    <= '0;
      entry_q  <= '0;
      cmp_q    <= 1'b0;
      tries_q  <= '0;
      siren_q  <= 1'b0;
      strobe_q <= 1'b0;
      req_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      pat_q    <= pat_d;
      tmo_q    <= tmo_d;
      wc_q     <= wc_d;
      idx_q    <= idx_d;
      entry_q  <= entry_d;
      cmp_q    <= cmp_d;
      tries_q  <= tries_d;
      siren_q  <= siren_d;
      strobe_q <= strobe_d;
      req_q    <= req_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pat_d   = pat_q;
    tmo_d   = tmo_q;
    wc_d    = wc_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    cmp_d   = 1'b0;
    tries_d = tries_q;
    running = state_q inside {SOUNDING, REQ, LOCKOUT};
    tick    = running && (presc_q == PRESC_MAX);

    if (running) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) pat_d = (pat_q == PAT_MAX) ? '0 : pat_q + PATW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.alarm_in) begin
          state_d = SOUNDING;
          presc_d = '0;
          pat_d   = '0;
          tmo_d   = '0;
          idx_d   = '0;
        end
      end
      SOUNDING: begin
        if (!bus.alarm_in) begin
          state_d = IDLE;
          idx_d   = '0;
          tries_d = '0;
        end else if (cmp_q) begin
          if (entry_q == CODE) begin
            state_d = REQ;
            tries_d = '0;
          end else begin
            tries_d = tries_q + 3'd1;
            if (tries_d == TRY_MAX) state_d = LOCKOUT;
          end
        end else if (bus.key_valid) begin
          entry_d = {entry_q[11:0], bus.key_data};
          tmo_d   = '0;
          if (idx_q == 2'd3) begin
            idx_d = '0;
            cmp_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (tick) begin
          // Saturating tick count since the last key; only discards a partial entry
          if (tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);
          if ((idx_q != 2'd0) && (tmo_d == TMO_MAX)) idx_d = '0;
        end
      end
      REQ: begin
        if (!bus.alarm_in) begin
          state_d = IDLE;
        end else if (bus.disarm_ack) begin
          state_d = WAIT_CLEAR;
          wc_d    = '0;
        end
      end
      WAIT_CLEAR: begin
        if (!bus.alarm_in) begin
          state_d = IDLE;
        end else if (wc_q == WC_MAX) begin
          state_d = SOUNDING;
          presc_d = '0;
          pat_d   = '0;
          tmo_d   = '0;
        end else begin
          wc_d = wc_q + WCW'(1);
        end
      end
      LOCKOUT: ;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state so they change on the transition edge
    siren_d  = (state_d inside {SOUNDING, REQ}) ? (pat_d < PAT_ON) : (state_d == LOCKOUT);
    strobe_d = tick && (state_d inside {SOUNDING, REQ, LOCKOUT});
    req_d    = (state_d == REQ);
    lock_d   = (state_d == LOCKOUT);
  end

  assign bus.siren      = siren_q;
  assign bus.strobe     = strobe_q;
  assign bus.disarm_req = req_q;
  assign bus.lockout    = lock_q;
  assign bus.status     = state_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb/tb_alarm_annunciator.sv - scoreboard bench for alarm_annunciator against a timing-arithmetic model
module tb_alarm_annunciator;

  localparam int          P    = 4;
  localparam int          ON   = 2;
  localparam int          OFF  = 2;
  localparam int          DT   = 3;
  localparam int          MT   = 3;
  localparam logic [15:0] CODE = 16'h1234;

  localparam int S_IDLE = 0, S_SOUND = 1, S_REQ = 2, S_WC = 3, S_LOCK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_annunciator_if bus_if ();

  alarm_annunciator #(
    .CODE(CODE), .PRESCALE(P), .SIREN_ON_TICKS(ON), .SIREN_OFF_TICKS(OFF),
    .DIGIT_TIMEOUT(DT), .MAX_TRIES(MT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // {status[2:0], siren, strobe, disarm_req, lockout}
  logic [6:0] exp_q[$];

  int         m_state, m_t, m_keytick, m_tries, m_wc;
  int         m_digits[$];
  bit         m_pend;
  logic [15:0] m_code_val;

  function automatic logic [6:0] dut_out();
    return {bus_if.status, bus_if.siren, bus_if.strobe, bus_if.disarm_req, bus_if.lockout};
  endfunction

  function automatic void check(string name, logic [6:0] got, logic [6:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t status/siren/strobe/req/lock got %b want %b", name, $time, got, want);
  endfunction

  function automatic void model_reset();
    m_state = S_IDLE; m_t = 0; m_keytick = 0; m_tries = 0; m_wc = 0;
    m_digits.delete(); m_pend = 0; m_code_val = '0;
  endfunction

  function automatic bit is_running(int s);
    return (s == S_SOUND) || (s == S_REQ) || (s == S_LOCK);
  endfunction

  // One clock edge of the reference: elapsed-cycle arithmetic gives ticks and siren phase
  task automatic model_step(input bit a, input bit kv, input logic [3:0] kd, input bit ack);
    int  old  = m_state;
    int  ns   = old;
    bit  tick = is_running(old) && ((m_t % P) == P - 1);
    int  tn   = is_running(old) ? m_t + 1 : m_t;
    bit  siren;
    case (old)
      S_IDLE: if (a) ns = S_SOUND;
      S_SOUND: begin
        if (!a) begin
          ns = S_IDLE; m_digits.delete(); m_tries = 0; m_pend = 0;
        end else if (m_pend) begin
          m_pend = 0;
          if (m_code_val == CODE) begin
            ns = S_REQ; m_tries = 0;
          end else begin
            m_tries++;
            if (m_tries == MT) ns = S_LOCK;
          end
        end else if (kv) begin
          m_digits.push_back(int'(kd));
          m_keytick = tn / P;
          if (m_digits.size() == 4) begin
            m_code_val = 16'(m_digits[0] * 4096 + m_digits[1] * 256 + m_digits[2] * 16 + m_digits[3]);
            m_digits.delete();
            m_pend = 1;
          end
        end else if (m_digits.size() != 0 && (tn / P - m_keytick) >= DT) begin
          m_digits.delete();
        end
      end
      S_REQ: begin
        if (!a) ns = S_IDLE;
        else if (ack) begin ns = S_WC; m_wc = 0; end
      end
      S_WC: begin
        if (!a) ns = S_IDLE;
        else if (m_wc + 1 == 2 * P) ns = S_SOUND;
        else m_wc++;
      end
      default: ;
    endcase
    if (ns == S_SOUND && (old == S_IDLE || old == S_WC)) begin
      m_t = 0; m_keytick = 0;
    end else begin
      m_t = tn;
    end
    m_state = ns;
    if (ns == S_SOUND || ns == S_REQ) siren = ((m_t / P) % (ON + OFF)) < ON;
    else siren = (ns == S_LOCK);
    exp_q.push_back({3'(ns), siren, tick && is_running(ns), ns == S_REQ, ns == S_LOCK});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle_out", dut_out(), exp_q.pop_front());
  end

  task automatic cycle(input bit a, input bit kv, input logic [3:0] kd, input bit ack);
    bus_if.alarm_in = a; bus_if.key_valid = kv; bus_if.key_data = kd; bus_if.disarm_ack = ack;
    @(posedge clk);
    model_step(a, kv, kd, ack);
    #1;
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) cycle(a, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic keys(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, code[15-4*i -: 4], 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 1'b0);
    end
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check(name, dut_out(), 7'b0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got timeout want completion", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] code_v;
    bit          r_alarm;
    int          pause, code_pos;
    code_v = CODE;
    model_reset();
    bus_if.alarm_in = 0; bus_if.key_valid = 0; bus_if.key_data = 0; bus_if.disarm_ack = 0;
    #12 check("reset_state", dut_out(), 7'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Alarm at cycle 10, siren pattern and strobe
    idle(10, 1'b0);
    idle(40, 1'b1);
    // Correct code, ack, clear
    keys(16'h1234);
    idle(3, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    idle(2, 1'b1);
    idle(3, 1'b0);
    // Controller refuses to clear: WAIT_CLEAR times out back to SOUNDING
    idle(2, 1'b1);
    keys(16'h1234);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    idle(14, 1'b1);
    // Three wrong codes lock out; later code and alarm drop ignored
    keys(16'h9999);
    keys(16'h9999);
    keys(16'h9999);
    idle(5, 1'b1);
    keys(16'h1234);
    idle(10, 1'b0);
    async_reset_check("lockout_reset");
    // Partial entry discarded by digit timeout
    idle(3, 1'b1);
    cycle(1'b1, 1'b1, 4'h1, 1'b0);
    cycle(1'b1, 1'b1, 4'h2, 1'b0);
    idle(12, 1'b1);
    keys(16'h3412);
    idle(4, 1'b1);
    idle(2, 1'b0);
    // Key in the same cycle as alarm rising is ignored
    cycle(1'b1, 1'b1, 4'h1, 1'b0);
    keys(16'h1234);
    idle(2, 1'b1);
    // Alarm drop during REQ
    idle(2, 1'b0);
    idle(2, 1'b1);
    keys(16'h1234);
    idle(2, 1'b1);
    idle(2, 1'b0);
    // Asynchronous reset during REQ
    idle(1, 1'b1);
    keys(16'h1234);
    idle(1, 1'b1);
    async_reset_check("async_reset_in_req");

    r_alarm = 1'b0; pause = 0; code_pos = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          kv, ack;
      logic [3:0]  kd;
      if (m_state == S_LOCK && $urandom_range(0, 19) == 0) begin
        async_reset_check("random_reset");
        r_alarm = 1'b0;
        continue;
      end
      if (r_alarm) begin
        if ($urandom_range(0, (m_state == S_WC) ? 5 : 80) == 0) r_alarm = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        r_alarm = 1'b1;
      end
      if (pause > 0) begin
        pause--;
        kv = 1'b0;
      end else begin
        if ($urandom_range(0, 39) == 0) pause = $urandom_range(8, 16);
        kv = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 3) == 0) kd = 4'($urandom_range(0, 9));
      else kd = 4'((code_v >> (12 - 4 * code_pos)) & 16'hF);
      if (kv) code_pos = (code_pos + 1) % 4;
      ack = ($urandom_range(0, 4) == 0);
      cycle(r_alarm, kv, kd, ack);
    end

    idle(2, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
